// File: rtl/colour_pkg.sv
// Shared definitions for the colour-detection path: count width, colour codes
// and the sequencer state encoding.
package colour_pkg;

  localparam int COUNT_W = 12;

  typedef enum logic [1:0] {
    COL_NONE  = 2'b00,
    COL_RED   = 2'b01,
    COL_GREEN = 2'b10,
    COL_BLUE  = 2'b11
  } color_t;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CAPTURE    = 3'd1;
  localparam logic [2:0] S_SORT_START = 3'd2;
  localparam logic [2:0] S_SORT_WAIT  = 3'd3;
  localparam logic [2:0] S_DECIDE     = 3'd4;
  localparam logic [2:0] S_REPORT     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE       = S_IDLE,
    ST_CAPTURE    = S_CAPTURE,
    ST_SORT_START = S_SORT_START,
    ST_SORT_WAIT  = S_SORT_WAIT,
    ST_DECIDE     = S_DECIDE,
    ST_REPORT     = S_REPORT
  } state_t;

endpackage

// File: rtl/dominant_color_pick.sv
// Combinational dominant-colour selection: largest count wins, ties resolve
// red > green > blue, and a winner below MIN_PIXELS is reported as NONE.
module dominant_color_pick
  import colour_pkg::*;
#(
  parameter logic [COUNT_W-1:0] MIN_PIXELS = 12'd300
) (
  input  logic [COUNT_W-1:0] red_cnt,
  input  logic [COUNT_W-1:0] green_cnt,
  input  logic [COUNT_W-1:0] blue_cnt,
  output color_t             color,
  output logic [COUNT_W-1:0] count
);

  color_t             win_color;
  logic [COUNT_W-1:0] max_cnt;

  always_comb begin
    win_color = COL_RED;
    max_cnt   = red_cnt;
    // Strict compares give the earlier colour priority on ties.
    if (green_cnt > max_cnt) begin
      win_color = COL_GREEN;
      max_cnt   = green_cnt;
    end
    if (blue_cnt > max_cnt) begin
      win_color = COL_BLUE;
      max_cnt   = blue_cnt;
    end
    color = (max_cnt < MIN_PIXELS) ? COL_NONE : win_color;
    count = max_cnt;
  end

endmodule

// File: rtl/color_classify_ctrl.sv
// Colour-classification sequencer: frame capture, sorter run, dominant-colour
// decision and valid/ready result hand-off, with a watchdog on both waits.
module color_classify_ctrl
  import colour_pkg::*;
#(
  parameter logic [COUNT_W-1:0] MIN_PIXELS = 12'd300,
  parameter int                 TO_W       = 24,
  parameter logic [TO_W-1:0]    TIMEOUT    = 24'd2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               auto_mode,
  output logic               cam_capture_req,
  input  logic               cam_frame_done,
  output logic               sort_pixels,
  input  logic               sorter_done,
  input  logic [COUNT_W-1:0] red_cnt,
  input  logic [COUNT_W-1:0] green_cnt,
  input  logic [COUNT_W-1:0] blue_cnt,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [1:0]         result_color,
  output logic [COUNT_W-1:0] result_count,
  output logic               busy,
  output logic               timeout_err
);

  localparam logic [TO_W-1:0] WD_LAST = TIMEOUT - TO_W'(1);

  state_t             state_reg;
  logic [TO_W-1:0]    wd_reg;
  logic [TO_W-1:0]    wd_next;
  logic               wd_expired;
  logic [COUNT_W-1:0] red_reg, green_reg, blue_reg;
  color_t             pick_color;
  logic [COUNT_W-1:0] pick_count;

  // Saturating watchdog increment.
  assign wd_next    = (wd_reg == '1) ? wd_reg : wd_reg + TO_W'(1);
  assign wd_expired = (wd_reg == WD_LAST);

  dominant_color_pick #(
    .MIN_PIXELS (MIN_PIXELS)
  ) u_pick (
    .red_cnt   (red_reg),
    .green_cnt (green_reg),
    .blue_cnt  (blue_reg),
    .color     (pick_color),
    .count     (pick_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      wd_reg          <= '0;
      red_reg         <= '0;
      green_reg       <= '0;
      blue_reg        <= '0;
      cam_capture_req <= 1'b0;
      sort_pixels     <= 1'b0;
      result_valid    <= 1'b0;
      result_color    <= COL_NONE;
      result_count    <= '0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg       <= ST_CAPTURE;
            wd_reg          <= '0;
            timeout_err     <= 1'b0;
            cam_capture_req <= 1'b1;
            busy            <= 1'b1;
          end
        end

        ST_CAPTURE: begin
          // Done is checked first so a same-cycle expiry loses.
          if (cam_frame_done) begin
            state_reg       <= ST_SORT_START;
            cam_capture_req <= 1'b0;
            sort_pixels     <= 1'b1;
          end else if (wd_expired) begin
            state_reg       <= ST_REPORT;
            cam_capture_req <= 1'b0;
            result_color    <= COL_NONE;
            result_count    <= '0;
            result_valid    <= 1'b1;
            timeout_err     <= 1'b1;
          end else begin
            wd_reg <= wd_next;
          end
        end

        ST_SORT_START: begin
          state_reg   <= ST_SORT_WAIT;
          sort_pixels <= 1'b0;
          wd_reg      <= '0;
        end

        ST_SORT_WAIT: begin
          // Counts are only valid alongside sorter_done, so latch them now.
          if (sorter_done) begin
            state_reg <= ST_DECIDE;
            red_reg   <= red_cnt;
            green_reg <= green_cnt;
            blue_reg  <= blue_cnt;
          end else if (wd_expired) begin
            state_reg    <= ST_REPORT;
            result_color <= COL_NONE;
            result_count <= '0;
            result_valid <= 1'b1;
            timeout_err  <= 1'b1;
          end else begin
            wd_reg <= wd_next;
          end
        end

        ST_DECIDE: begin
          state_reg    <= ST_REPORT;
          result_color <= pick_color;
          result_count <= pick_count;
          result_valid <= 1'b1;
        end

        ST_REPORT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (auto_mode) begin
              state_reg       <= ST_CAPTURE;
              wd_reg          <= '0;
              timeout_err     <= 1'b0;
              cam_capture_req <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
              busy      <= 1'b0;
            end
          end
        end

        default: begin
          state_reg       <= ST_IDLE;
          cam_capture_req <= 1'b0;
          sort_pixels     <= 1'b0;
          result_valid    <= 1'b0;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule
